// File: rtl/ndn_fib_pkg.sv
// Shared types and sizes for the NDN FIB front end (name stream packer and lookup).
// The word-fold helper here is used by name_hash_fold when NAME_HASH_EN is defined.
package ndn_fib_pkg;

    localparam int WORD_SIZE       = 64;
    localparam int MAX_NAME_LENGTH = 16;
    localparam int POINTER_SIZE    = 16;
    localparam int LEN_W           = $clog2(MAX_NAME_LENGTH + 1);
    localparam int IDX_W           = $clog2(MAX_NAME_LENGTH);
    localparam int SLICES          = WORD_SIZE / POINTER_SIZE;

    typedef logic [WORD_SIZE-1:0]                 name_word_t;
    typedef name_word_t [MAX_NAME_LENGTH-1:0]     name_bus_t;
    typedef logic [LEN_W-1:0]                     name_len_t;
    typedef logic [POINTER_SIZE-1:0]              name_hash_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } packer_state_e;

    // One fold step: rotate the running hash left by one, then mix in every slice of the word.
    function automatic name_hash_t fold_word(input name_hash_t h, input name_word_t w);
        name_hash_t acc;
        acc = {h[POINTER_SIZE-2:0], h[POINTER_SIZE-1]};
        for (int i = 0; i < SLICES; i++) begin
            acc = acc ^ w[i*POINTER_SIZE +: POINTER_SIZE];
        end
        return acc;
    endfunction

endpackage

// File: rtl/name_stream_packer_hash_fold.sv
// Combinational fold step for the optional name hash (instantiated only with NAME_HASH_EN).
module name_hash_fold
    import ndn_fib_pkg::*;
(
    input  logic [POINTER_SIZE-1:0] hash_in,
    input  logic [WORD_SIZE-1:0]    word_in,
    output logic [POINTER_SIZE-1:0] hash_out
);

    assign hash_out = fold_word(hash_in, word_in);

endmodule

// File: rtl/name_stream_packer.sv
// Packs a last-flagged word stream into the parallel name bus consumed by the FIB lookup.
// Optional feature macro: NAME_HASH_EN adds the name_hash output and its fold logic.
module name_stream_packer
    import ndn_fib_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [WORD_SIZE-1:0]                 in_word,
    input  logic                                 in_last,
    output logic [MAX_NAME_LENGTH*WORD_SIZE-1:0] name_out,
    output logic [LEN_W-1:0]                     name_len,
    output logic                                 name_trunc,
    output logic                                 name_valid,
    input  logic                                 name_ready
`ifdef NAME_HASH_EN
    ,
    output logic [POINTER_SIZE-1:0]              name_hash
`endif
);

    packer_state_e state_r;
    packer_state_e state_next_s;
    name_bus_t     buf_r;
    name_len_t     len_r;
    logic          trunc_r;
    logic          in_ready_r;
    logic          name_valid_r;

    logic          xfer_s;
    logic          store_s;
    logic          trunc_set_s;
    logic          clear_s;
    logic          full_s;
    logic [IDX_W-1:0] idx_s;

    assign xfer_s = in_valid & in_ready_r;
    assign full_s = (len_r == name_len_t'(MAX_NAME_LENGTH));
    assign idx_s  = len_r[IDX_W-1:0];

    // Next-state decode and datapath strobes for the stream/name handshakes.
    always_comb begin
        state_next_s = state_r;
        store_s      = 1'b0;
        trunc_set_s  = 1'b0;
        clear_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s) begin
                    store_s      = 1'b1;
                    state_next_s = in_last ? ST_HOLD : ST_FILL;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (xfer_s && full_s) begin
                    trunc_set_s  = 1'b1;
                    state_next_s = in_last ? ST_HOLD : ST_DRAIN;
                end else if (xfer_s) begin
                    store_s      = 1'b1;
                    state_next_s = in_last ? ST_HOLD : ST_FILL;
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (xfer_s && in_last) begin
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                if (name_valid_r && name_ready) begin
                    clear_s      = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: begin
                clear_s      = 1'b1;
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, handshake flags and name buffer; in_ready stays low until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            in_ready_r   <= 1'b0;
            name_valid_r <= 1'b0;
            buf_r        <= '0;
            len_r        <= '0;
            trunc_r      <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            in_ready_r   <= (state_next_s != ST_HOLD);
            name_valid_r <= (state_next_s == ST_HOLD);
            if (clear_s) begin
                buf_r   <= '0;
                len_r   <= '0;
                trunc_r <= 1'b0;
            end else begin
                if (store_s) begin
                    buf_r[idx_s] <= in_word;
                    len_r        <= len_r + name_len_t'(1);
                end
                if (trunc_set_s) begin
                    trunc_r <= 1'b1;
                end
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign name_valid = name_valid_r;
    assign name_out   = buf_r;
    assign name_len   = len_r;
    assign name_trunc = trunc_r;

`ifdef NAME_HASH_EN
    name_hash_t hash_r;
    name_hash_t hash_next_s;

    name_hash_fold u_hash_fold (
        .hash_in  (hash_r),
        .word_in  (in_word),
        .hash_out (hash_next_s)
    );

    // Running hash advances only on stored words, so truncated words never reach it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hash_r <= '0;
        end else if (clear_s) begin
            hash_r <= '0;
        end else if (store_s) begin
            hash_r <= hash_next_s;
        end
    end

    assign name_hash = hash_r;
`endif

endmodule

// File: tb/tb_name_stream_packer.sv
// Scoreboard bench for name_stream_packer: randomized names checked against a queue-based model.
module tb_name_stream_packer;
    import ndn_fib_pkg::*;

    logic                                 clk = 1'b0;
    logic                                 rst_n = 1'b0;
    logic                                 in_valid = 1'b0;
    logic                                 in_ready;
    logic [WORD_SIZE-1:0]                 in_word = '0;
    logic                                 in_last = 1'b0;
    logic [MAX_NAME_LENGTH*WORD_SIZE-1:0] name_out;
    logic [LEN_W-1:0]                     name_len;
    logic                                 name_trunc;
    logic                                 name_valid;
    logic                                 name_ready = 1'b0;
`ifdef NAME_HASH_EN
    logic [POINTER_SIZE-1:0]              name_hash;
`endif

    name_stream_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_word    (in_word),
        .in_last    (in_last),
        .name_out   (name_out),
        .name_len   (name_len),
        .name_trunc (name_trunc),
        .name_valid (name_valid),
        .name_ready (name_ready)
`ifdef NAME_HASH_EN
        ,
        .name_hash  (name_hash)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MAX_NAME_LENGTH*WORD_SIZE-1:0] bus;
        int                                   len;
        bit                                   trunc;
        logic [POINTER_SIZE-1:0]              hash;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   ready_mode = 0;   // 0 random, 1 held low, 2 held high
    bit   have_cur = 1'b0;
    bit   post_check = 1'b0;
    exp_t cur;

    task automatic chk(input string nm, input logic [MAX_NAME_LENGTH*WORD_SIZE-1:0] got,
                       input logic [MAX_NAME_LENGTH*WORD_SIZE-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference: keep the first MAX_NAME_LENGTH words, zero the rest, fold stored words into hash.
    function automatic exp_t model(input logic [WORD_SIZE-1:0] w[$]);
        exp_t e;
        logic [POINTER_SIZE-1:0] h;
        e.bus   = '0;
        e.len   = (w.size() > MAX_NAME_LENGTH) ? MAX_NAME_LENGTH : w.size();
        e.trunc = (w.size() > MAX_NAME_LENGTH);
        h = '0;
        for (int i = 0; i < e.len; i++) begin
            e.bus[i*WORD_SIZE +: WORD_SIZE] = w[i];
            h = {h[POINTER_SIZE-2:0], h[POINTER_SIZE-1]};
            for (int s = 0; s < WORD_SIZE / POINTER_SIZE; s++)
                h = h ^ w[i][s*POINTER_SIZE +: POINTER_SIZE];
        end
        e.hash = h;
        return e;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"},   {1023'd0, in_ready},   1024'd0);
        chk({tag, "_name_valid"}, {1023'd0, name_valid}, 1024'd0);
        chk({tag, "_name_out"},   name_out,              1024'd0);
        chk({tag, "_name_len"},   {1019'd0, name_len},   1024'd0);
        chk({tag, "_name_trunc"}, {1023'd0, name_trunc}, 1024'd0);
`ifdef NAME_HASH_EN
        chk({tag, "_name_hash"},  {1008'd0, name_hash},  1024'd0);
`endif
    endtask

    // Sends a name word by word; abort_after > 0 stops after that many accepted words.
    task automatic send_name(input logic [WORD_SIZE-1:0] w[$], input int abort_after);
        bit acc;
        int guard;
        for (int i = 0; i < w.size(); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_word  = {$urandom, $urandom};
                in_last  = $urandom_range(0, 1);
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_word  = w[i];
            in_last  = (i == w.size() - 1);
            guard = 0;
            acc = 1'b0;
            while (!acc && guard < 1000) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                guard++;
            end
            if (!acc) begin
                tests++;
                fails++;
                $display("FAIL word_accept_timeout: got no in_ready expected in_ready within 1000 cycles");
                in_valid = 1'b0;
                return;
            end
            if (abort_after > 0 && i + 1 == abort_after) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        sb.push_back(model(w));
    endtask

    task automatic wait_drained(input string tag);
        int n = 0;
        while ((sb.size() != 0 || have_cur) && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb.size() != 0 || have_cur) begin
            tests++;
            fails++;
            $display("FAIL %s_drain_timeout: got %0d names pending expected 0", tag, sb.size());
        end
    endtask

    // Consumer: name_ready changes just after the rising edge.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1:       name_ready = 1'b0;
            2:       name_ready = 1'b1;
            default: name_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Monitor: compares presented names against the scoreboard every cycle they are held.
    always @(negedge clk) begin
        if (!rst_n) begin
            have_cur   = 1'b0;
            post_check = 1'b0;
        end else begin
            if (post_check) begin
                post_check = 1'b0;
                chk("after_take_valid",    {1023'd0, name_valid}, 1024'd0);
                chk("after_take_in_ready", {1023'd0, in_ready},   1024'd1);
                chk("after_take_buffer",   name_out,              1024'd0);
                chk("after_take_len",      {1019'd0, name_len},   1024'd0);
            end
            if (name_valid) begin
                if (!have_cur) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_name: got name_len %0d expected no name", name_len);
                    end else begin
                        cur = sb.pop_front();
                        have_cur = 1'b1;
                    end
                end
                if (have_cur) begin
                    chk("name_out",   name_out,              cur.bus);
                    chk("name_len",   {1019'd0, name_len},   1024'(cur.len));
                    chk("name_trunc", {1023'd0, name_trunc}, {1023'd0, cur.trunc});
`ifdef NAME_HASH_EN
                    chk("name_hash",  {1008'd0, name_hash},  {1008'd0, cur.hash});
`endif
                    chk("hold_in_ready", {1023'd0, in_ready}, 1024'd0);
                    if (name_ready) begin
                        have_cur   = 1'b0;
                        post_check = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        logic [WORD_SIZE-1:0] w[$];
        int n;

        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single word with last.
        w = {64'hA5};
        send_name(w, 0);
        wait_drained("single");

        // Three words, consumer stalls several cycles.
        ready_mode = 1;
        w = {64'h1, 64'h2, 64'h3};
        send_name(w, 0);
        repeat (6) @(posedge clk);
        ready_mode = 2;
        wait_drained("stall");
        ready_mode = 0;

        // Exactly full name, then an overlong one.
        w.delete();
        for (int i = 0; i < 16; i++) w.push_back(64'h10 + 64'(i));
        send_name(w, 0);
        w.delete();
        for (int i = 0; i < 20; i++) w.push_back(64'h20 + 64'(i));
        send_name(w, 0);
        wait_drained("full_trunc");

        // Reset in the middle of a name discards it.
        w = {64'h41, 64'h42, 64'h43, 64'h44, 64'h45};
        send_name(w, 3);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("mid_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        w = {64'h77};
        send_name(w, 0);
        wait_drained("after_reset");

        // Hash folding example.
        w = {64'h1, 64'h2};
        send_name(w, 0);
        wait_drained("hash");

        // Randomized names, lengths straddling the buffer depth.
        for (int k = 0; k < 40; k++) begin
            w.delete();
            n = (k % 5 == 0) ? $urandom_range(15, 20) : $urandom_range(1, 20);
            for (int i = 0; i < n; i++) w.push_back({$urandom, $urandom});
            send_name(w, 0);
        end
        wait_drained("random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
